alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating illegal-instruction counter.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: flush  in  1  synchronous discard of all buffered entries.
REQ-005 Port: in_valid  in  1  upstream beat valid.
REQ-006 Port: in_ready  out  1  block accepts a beat this cycle.
REQ-007 Port: in_instr  in  32  RV32I instruction word.
REQ-008 Port: in_pc  in  32  instruction address.
REQ-009 Port: in_rs1_data, in_rs2_data  in  32 each  register-file read data.
REQ-010 Port: out_valid  out  1  issued beat valid.
REQ-011 Port: out_ready  in  1  downstream ALU stage accepts.
REQ-012 Port: out_in1, out_in2  out  32 each  ALU operands.
REQ-013 Port: out_alu_control  out  4  ALU operation code.
REQ-014 Port: out_rd  out  5  destination register index.
REQ-015 Port: out_wb_en  out  1  result written back.
REQ-016 Port: out_illegal  out  1  beat carries an undecodable instruction.
REQ-017 Port: out_illegal_cnt  out  CNT_W  count of accepted illegal beats.

Function
REQ-018 Codes SHALL be: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-019 OP (0110011): in1=rs1, in2=rs2; funct7 0000000 for all funct3, 0100000 only with funct3 000 (SUB) or 101 (SRA); else illegal.
REQ-020 OP-IMM (0010011): in1=rs1, in2=sign-extended I-imm; SLLI needs funct7 0000000, SRLI/SRAI 0000000/0100000; else illegal.
REQ-021 Any shift SHALL present in2 with bits [31:5] zero (shamt or rs2[4:0]).
REQ-022 LUI (0110111): in1=0, in2={imm[31:12],12'b0}, ADD; AUIPC (0010111): in1=pc, same in2, ADD.
REQ-023 Other opcodes illegal: out_illegal=1, out_wb_en=0, out_alu_control=ADD, operands 0.
REQ-024 out_wb_en=1 only for legal beats with rd != 0.
REQ-025 Beat accepted when in_valid && in_ready; transfer when out_valid && out_ready.
REQ-026 Storage: output register plus one skid entry; latency 1 cycle from acceptance to out_valid when empty; full throughput 1 beat/cycle with out_ready held high.
REQ-027 in_ready SHALL be registered, equal to NOT skid-entry-occupied; no combinational path out_ready to in_ready.
REQ-028 Output stalled and new beat accepted: beat goes to skid; skid drains into output on next transfer, in order.
REQ-029 Output payload SHALL stay stable while out_valid && !out_ready.
REQ-030 flush: both entries invalid next cycle; in_ready=0 during flush cycle; beat presented that cycle is dropped, not counted.
REQ-031 out_illegal_cnt increments per accepted illegal beat, saturates at all-ones, unaffected by flush.

Reset
REQ-032 rst SHALL clear out_valid, skid valid, out_illegal_cnt to 0 and set in_ready 1 next cycle; payload registers cleared to 0.
REQ-033 rst overrides flush and in-flight beats; beats presented during rst are dropped.

Structure
REQ-034 Shared package holds ALU code constants (REQ-018), opcode constants, funct7 constants.
REQ-035 One sub-module alu_decode: purely combinational instruction-to-{in1,in2,code,rd,wb_en,illegal}; handshake/skid/counter in alu_issue.

Verification
REQ-036 ADD x3,x1,x2 (rs1=5, rs2=7), out_ready=1 -> next cycle out_valid=1, in1=5, in2=7, code 0000, rd=3, wb_en=1.
REQ-037 SRAI x4,x1,3 (0x4030D213) -> code 0111, in2=3; OP funct7 0000001 -> illegal=1, wb_en=0, cnt+1.
REQ-038 AUIPC x5,0x12345 at pc 0x100 -> in1=0x100, in2=0x12345000, code 0000.
REQ-039 Three back-to-back beats, out_ready=0 -> two held, in_ready 0 after second; release -> order A,B,C, none lost/duplicated.
REQ-040 flush with both entries full and in_valid=1 -> out_valid=0, in_ready=1 next cycle, cnt unchanged; 0xFFFF illegal beats -> cnt stays 0xFFFF.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue slice.
// Holds ALU op codes, RV32I opcode/funct7 values and the issue payload bundle.
`timescale 1ns/1ps
package alu_issue_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  code;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } issue_t;

  // alt selects SUB over ADD and SRA over SRL.
  function automatic logic [3:0] f3_code(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] c;
    c = ALU_ADD;
    case (f3)
      3'b000: c = alt ? ALU_SUB : ALU_ADD;
      3'b001: c = ALU_SLL;
      3'b010: c = ALU_SLT;
      3'b011: c = ALU_SLTU;
      3'b100: c = ALU_XOR;
      3'b101: c = alt ? ALU_SRA : ALU_SRL;
      3'b110: c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-class decoder: instruction -> operands, code, rd.
// Ports: instr/pc/rs1_data/rs2_data in; in1/in2/code/rd/wb_en/illegal out.
`timescale 1ns/1ps
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [3:0]  code,
  output logic [4:0]  rd,
  output logic        wb_en,
  output logic        illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm;
  logic [31:0] u_imm;
  logic        shift;
  logic        legal;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  c;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign u_imm = {instr[31:12], 12'b0};
  assign shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    legal = 1'b0;
    a     = '0;
    b     = '0;
    c     = ALU_ADD;
    case (opc)
      OPC_OP: begin
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) &&
                 ((f3 == 3'b000) || (f3 == 3'b101)));
        a = rs1_data;
        b = shift ? {27'b0, rs2_data[4:0]} : rs2_data;
        c = f3_code(f3, f7[5]);
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001)
          legal = (f7 == F7_BASE);
        else if (f3 == 3'b101)
          legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else
          legal = 1'b1;
        a = rs1_data;
        b = shift ? {27'b0, instr[24:20]} : i_imm;
        // imm bit 30 only means "alt" for right shifts
        c = f3_code(f3, (f3 == 3'b101) && f7[5]);
      end
      OPC_LUI: begin
        legal = 1'b1;
        b     = u_imm;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a     = pc;
        b     = u_imm;
      end
      default: legal = 1'b0;
    endcase
  end

  assign in1     = legal ? a : '0;
  assign in2     = legal ? b : '0;
  assign code    = legal ? c : ALU_ADD;
  assign rd      = legal ? instr[11:7] : '0;
  assign wb_en   = legal && (instr[11:7] != 5'd0);
  assign illegal = ~legal;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes a beat into an output register with one skid entry.
// Ports: clk/rst/flush; in_* valid/ready beat; out_* issued beat; illegal count.
`timescale 1ns/1ps
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_in1,
  output logic [31:0]      out_in2,
  output logic [3:0]       out_alu_control,
  output logic [4:0]       out_rd,
  output logic             out_wb_en,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_illegal_cnt
);

  issue_t           dec;
  issue_t           out_q;
  issue_t           skid_q;
  logic             out_v;
  logic             skid_v;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             free;

  alu_decode u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .in1      (dec.in1),
    .in2      (dec.in2),
    .code     (dec.code),
    .rd       (dec.rd),
    .wb_en    (dec.wb_en),
    .illegal  (dec.illegal)
  );

  // ready_q mirrors "skid empty"; flush/rst only mask it for one cycle
  assign in_ready = ready_q & ~flush & ~rst;
  assign accept   = in_valid & in_ready;
  assign free     = ~out_v | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept && dec.illegal && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
      if (flush) begin
        out_v   <= 1'b0;
        skid_v  <= 1'b0;
        ready_q <= 1'b1;
      end else if (free) begin
        // skid occupied implies no accept this cycle
        if (skid_v) begin
          out_q   <= skid_q;
          out_v   <= 1'b1;
          skid_v  <= 1'b0;
          ready_q <= 1'b1;
        end else begin
          out_v <= accept;
          if (accept)
            out_q <= dec;
        end
      end else if (accept) begin
        skid_q  <= dec;
        skid_v  <= 1'b1;
        ready_q <= 1'b0;
      end
    end
  end

  assign out_valid       = out_v;
  assign out_in1         = out_q.in1;
  assign out_in2         = out_q.in2;
  assign out_alu_control = out_q.code;
  assign out_rd          = out_q.rd;
  assign out_wb_en       = out_q.wb_en;
  assign out_illegal     = out_q.illegal;
  assign out_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, skid ordering, flush, reset,
// and illegal-counter saturation.
`timescale 1ns/1ps
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [3:0]  out_alu_control;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;
  logic [15:0] out_illegal_cnt;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  alu_issue #(.CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_in1         (out_in1),
    .out_in2         (out_in2),
    .out_alu_control (out_alu_control),
    .out_rd          (out_rd),
    .out_wb_en       (out_wb_en),
    .out_illegal     (out_illegal),
    .out_illegal_cnt (out_illegal_cnt)
  );

  localparam logic [31:0] I_ADD   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
  localparam logic [31:0] I_SRAI  = 32'h4030D213;
  localparam logic [31:0] I_MUL   = {7'h01, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33};
  localparam logic [31:0] I_AUIPC = {20'h12345, 5'd5, 7'h17};
  localparam logic [31:0] I_SLL   = {7'h00, 5'd2, 5'd1, 3'd1, 5'd6, 7'h33};
  localparam logic [31:0] I_SUB   = {7'h20, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33};
  localparam logic [31:0] I_SLTU  = {7'h00, 5'd2, 5'd1, 3'd3, 5'd8, 7'h33};
  localparam logic [31:0] I_ADDIM = {12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13};
  localparam logic [31:0] I_SLLIX = {7'h20, 5'd3, 5'd1, 3'd1, 5'd2, 7'h13};
  localparam logic [31:0] I_ADD0  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33};
  localparam logic [31:0] I_LUI   = {20'hABCDE, 5'd10, 7'h37};
  localparam logic [31:0] I_A     = {12'd1, 5'd0, 3'd0, 5'd1, 7'h13};
  localparam logic [31:0] I_B     = {12'd2, 5'd0, 3'd0, 5'd1, 7'h13};
  localparam logic [31:0] I_C     = {12'd3, 5'd0, 3'd0, 5'd1, 7'h13};
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    in_instr    = i;
    in_pc       = p;
    in_rs1_data = a;
    in_rs2_data = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", out_illegal_cnt, 0);
    chk("rst_in1", out_in1, 0);

    send(I_ADD, 0, 5, 7);
    chk("add_valid", out_valid, 1);
    chk("add_in1", out_in1, 5);
    chk("add_in2", out_in2, 7);
    chk("add_code", out_alu_control, 4'b0000);
    chk("add_rd", out_rd, 3);
    chk("add_wb", out_wb_en, 1);
    chk("add_ill", out_illegal, 0);

    send(I_SRAI, 0, 32'h80000000, 0);
    chk("srai_code", out_alu_control, 4'b0111);
    chk("srai_in2", out_in2, 3);
    chk("srai_in1", out_in1, 32'h80000000);
    chk("srai_rd", out_rd, 4);

    send(I_MUL, 0, 5, 7);
    chk("f7bad_ill", out_illegal, 1);
    chk("f7bad_wb", out_wb_en, 0);
    chk("f7bad_code", out_alu_control, 4'b0000);
    chk("f7bad_in1", out_in1, 0);
    chk("f7bad_in2", out_in2, 0);
    chk("f7bad_cnt", out_illegal_cnt, 1);

    send(I_AUIPC, 32'h100, 9, 9);
    chk("auipc_in1", out_in1, 32'h100);
    chk("auipc_in2", out_in2, 32'h12345000);
    chk("auipc_code", out_alu_control, 4'b0000);
    chk("auipc_wb", out_wb_en, 1);

    send(I_SLL, 0, 1, 32'hFFFFFF23);
    chk("sll_code", out_alu_control, 4'b0101);
    chk("sll_in2", out_in2, 3);

    send(I_SUB, 0, 10, 3);
    chk("sub_code", out_alu_control, 4'b0001);
    chk("sub_in2", out_in2, 3);

    send(I_SLTU, 0, 1, 2);
    chk("sltu_code", out_alu_control, 4'b1001);

    send(I_ADDIM, 0, 32'h55, 0);
    chk("addi_in1", out_in1, 32'h55);
    chk("addi_in2", out_in2, 32'hFFFFFFFF);
    chk("addi_code", out_alu_control, 4'b0000);

    send(I_SLLIX, 0, 1, 0);
    chk("slli_ill", out_illegal, 1);
    chk("slli_cnt", out_illegal_cnt, 2);

    send(I_ADD0, 0, 1, 2);
    chk("rd0_wb", out_wb_en, 0);
    chk("rd0_ill", out_illegal, 0);

    send(I_LUI, 0, 32'hDEAD, 0);
    chk("lui_in1", out_in1, 0);
    chk("lui_in2", out_in2, 32'hABCDE000);
    chk("lui_rd", out_rd, 10);

    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", out_valid, 0);

    out_ready = 1'b0;
    send(I_A, 0, 0, 0);
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_in2", out_in2, 1);
    chk("bp_a_rdy", in_ready, 1);
    send(I_B, 0, 0, 0);
    chk("bp_b_hold", out_in2, 1);
    chk("bp_b_rdy", in_ready, 0);
    send(I_C, 0, 0, 0);
    chk("bp_c_hold", out_in2, 1);
    chk("bp_c_valid", out_valid, 1);
    chk("bp_c_rdy", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_b", out_in2, 2);
    chk("drain_rdy", in_ready, 1);
    @(posedge clk);
    #1;
    chk("drain_c", out_in2, 3);
    chk("drain_c_valid", out_valid, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_empty", out_valid, 0);

    out_ready = 1'b0;
    send(I_A, 0, 0, 0);
    send(I_B, 0, 0, 0);
    chk("fl_full_rdy", in_ready, 0);
    in_valid = 1'b1;
    in_instr = I_BAD;
    flush = 1'b1;
    #1;
    chk("fl_rdy_during", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    chk("fl_cnt", out_illegal_cnt, 2);
    @(posedge clk);
    #1;
    chk("fl_still_empty", out_valid, 0);
    out_ready = 1'b1;

    in_valid = 1'b1;
    in_instr = I_BAD;
    flush = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst2_cnt", out_illegal_cnt, 0);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_rdy", in_ready, 1);

    in_valid = 1'b1;
    in_instr = I_BAD;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach", out_illegal_cnt, 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", out_illegal_cnt, 32'hFFFF);
    chk("sat_ill", out_illegal, 1);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
